// File: rtl/spi_ctrl_fsm.sv
// SPI-slave transaction sequencer: frames command/data phases, strobes the
// address latch, shift register and data memory, and flags aborted frames.
module spi_ctrl_fsm #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned BURST_EN   = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sclk_rise,
  input  logic chipselect,
  input  logic rw_bit,
  output logic addr_latch_en,
  output logic sr_load,
  output logic dm_we,
  output logic addr_inc,
  output logic miso_en,
  output logic busy,
  output logic frame_err
);

  localparam int unsigned CMD_BITS = ADDR_WIDTH + 1;
  localparam int unsigned MAX_BITS = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS) + 1;

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               BURST     = (BURST_EN != 0);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_LATCH, S_RD_WAIT, S_RD_LOAD, S_RD_SHIFT, S_RD_INC,
    S_WR_SHIFT, S_WR_COMMIT, S_WR_INC, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic addr_latch_en_q, addr_latch_en_d;
  logic sr_load_q, sr_load_d;
  logic dm_we_q, dm_we_d;
  logic addr_inc_q, addr_inc_d;
  logic miso_en_q, miso_en_d;
  logic busy_q, busy_d;
  logic frame_err_q, frame_err_d;

  // Next state, counter and the outputs of the state being entered
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    if (chipselect) begin
      // Deselect wins over everything; mid-word or mid-command is a broken frame
      state_d     = S_IDLE;
      cnt_d       = '0;
      frame_err_d = (state_q == S_LATCH) ||
                    ((cnt_q != '0) && (state_q inside {S_CMD, S_WR_SHIFT, S_RD_SHIFT}));
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d   = '0;
          state_d = S_CMD;
        end
        S_CMD: if (sclk_rise) begin
          if (cnt_q == CMD_LAST) begin
            cnt_d   = '0;
            state_d = S_LATCH;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        S_LATCH:   state_d = rw_bit ? S_RD_WAIT : S_WR_SHIFT;
        S_RD_WAIT: begin
          if (cnt_q == LAT_LAST) begin
            cnt_d   = '0;
            state_d = S_RD_LOAD;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        S_RD_LOAD:  state_d = S_RD_SHIFT;
        S_RD_SHIFT: if (sclk_rise) begin
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = BURST ? S_RD_INC : S_DONE;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        S_RD_INC:   state_d = S_RD_WAIT;
        S_WR_SHIFT: if (sclk_rise) begin
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_WR_COMMIT;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        S_WR_COMMIT: state_d = BURST ? S_WR_INC : S_DONE;
        S_WR_INC:    state_d = S_WR_SHIFT;
        S_DONE:      state_d = S_DONE;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    addr_latch_en_d = (state_d == S_LATCH);
    sr_load_d       = (state_d == S_RD_LOAD);
    dm_we_d         = (state_d == S_WR_COMMIT);
    addr_inc_d      = (state_d == S_RD_INC) || (state_d == S_WR_INC);
    miso_en_d       = (state_d == S_RD_SHIFT);
    busy_d          = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      addr_latch_en_q <= 1'b0;
      sr_load_q       <= 1'b0;
      dm_we_q         <= 1'b0;
      addr_inc_q      <= 1'b0;
      miso_en_q       <= 1'b0;
      busy_q          <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_latch_en_q <= addr_latch_en_d;
      sr_load_q       <= sr_load_d;
      dm_we_q         <= dm_we_d;
      addr_inc_q      <= addr_inc_d;
      miso_en_q       <= miso_en_d;
      busy_q          <= busy_d;
      frame_err_q     <= frame_err_d;
    end
  end

  assign addr_latch_en = addr_latch_en_q;
  assign sr_load       = sr_load_q;
  assign dm_we         = dm_we_q;
  assign addr_inc      = addr_inc_q;
  assign miso_en       = miso_en_q;
  assign busy          = busy_q;
  assign frame_err     = frame_err_q;

endmodule
